// File: rtl/prog_memory.sv
// ---------------------------------------------------------------------------
// prog_memory
//
// Program memory for a small CPU. It holds 256 x 16-bit words and works
// through three phases:
//   CLEAR - fills every word with CLR_VAL, one address per clock.
//   LOAD  - accepts a program from a valid/ready loader stream.
//   RUN   - serves the CPU with registered, read-first reads and writes.
//
// Optional feature (macro PROG_MEMORY_WPROT_EN):
//   When defined, a RUN-state CPU write to an address below prog_len (that
//   is, inside the loaded program) is dropped. The sticky wr_fault flag is
//   set and stays set until rst. When the macro is absent, every RUN-state
//   write is performed and wr_fault is tied to 0.
//
// Parameters:
//   CLR_VAL    fill word that CLEAR writes to every location
//
// Ports:
//   clk        single clock; all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   cpu_addr   [7:0]  CPU address (MAR)
//   cpu_wdata  [15:0] CPU write data (MBR out)
//   cpu_we     CPU write strobe; honoured only in RUN
//   cpu_rdata  [15:0] registered read data; forced to 0 outside RUN
//   cpu_run    high in RUN; the CPU may leave reset
//   ld_valid   loader word valid
//   ld_data    [15:0] loader word (opcode[15:8], operand[7:0])
//   ld_last    marks the final loader word
//   ld_ready   high in LOAD; decoded from the state register only
//   prog_len   [8:0] number of words accepted from the loader (0..256)
//   wr_fault   sticky write-protect violation flag
//
// State table:
//   state   | meaning
//   S_CLEAR | fill mem[0..255] with CLR_VAL, one word per cycle
//   S_LOAD  | accept loader words at address prog_len
//   S_RUN   | CPU access; loader is ignored
// ---------------------------------------------------------------------------
module prog_memory #(
  parameter logic [15:0] CLR_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_we,
  output logic [15:0] cpu_rdata,
  output logic        cpu_run,
  input  logic        ld_valid,
  input  logic [15:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic [8:0]  prog_len,
  output logic        wr_fault
);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_clr_ptr;
  logic [8:0]  r_prog_len;
  logic [15:0] r_rdata;
  logic [15:0] r_mem [0:255];

  logic        w_in_load;
  logic        w_in_run;
  logic        w_ld_xfer;
  logic        w_prot_hit;
  logic        w_cpu_wr;
  logic        w_mem_we;
  logic [7:0]  w_mem_addr;
  logic [15:0] w_mem_wdata;

  assign w_in_load = (r_state == S_LOAD);
  assign w_in_run  = (r_state == S_RUN);

  // ld_ready depends only on the state register. The loader can then
  // qualify ld_valid from ld_ready without creating a combinational loop.
  assign ld_ready  = w_in_load;
  assign w_ld_xfer = ld_valid & w_in_load;

  assign cpu_run   = w_in_run;
  assign cpu_rdata = r_rdata;
  assign prog_len  = r_prog_len;

`ifdef PROG_MEMORY_WPROT_EN
  logic r_wr_fault;

  // prog_len is 9 bits, so after a full 256-word load every address is
  // protected.
  assign w_prot_hit = ({1'b0, cpu_addr} < r_prog_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_wr_fault <= 1'b0;
    else if (w_in_run && cpu_we && w_prot_hit)
      r_wr_fault <= 1'b1;
  end

  assign wr_fault = r_wr_fault;
`else
  assign w_prot_hit = 1'b0;
  assign wr_fault   = 1'b0;
`endif

  assign w_cpu_wr = cpu_we & w_in_run & ~w_prot_hit;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_CLEAR;
    else
      r_state <= w_state_nxt;
  end

  // Next state and the single memory write port. The three phases never
  // overlap, so one write port serves the clear, loader and CPU paths.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_clr_ptr;
    w_mem_wdata = CLR_VAL;
    case (r_state)
      S_CLEAR: begin
        w_mem_we = 1'b1;
        if (r_clr_ptr == 8'hFF)
          w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (w_ld_xfer) begin
          w_mem_we    = 1'b1;
          w_mem_addr  = r_prog_len[7:0];
          w_mem_wdata = ld_data;
          // Filling address 255 ends the load even without ld_last.
          // Because of this, prog_len stops at 256 and never wraps.
          if (ld_last || (r_prog_len[7:0] == 8'hFF))
            w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_cpu_wr) begin
          w_mem_we    = 1'b1;
          w_mem_addr  = cpu_addr;
          w_mem_wdata = cpu_wdata;
        end
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Clear pointer. It wraps back to 0 on the final CLEAR cycle, so a
  // later reset always starts the sweep from address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_clr_ptr <= 8'h00;
    else if (r_state == S_CLEAR)
      r_clr_ptr <= r_clr_ptr + 8'h01;
  end

  // Loader word count. It can only advance in LOAD, so it is frozen in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_prog_len <= 9'd0;
    else if (w_ld_xfer)
      r_prog_len <= r_prog_len + 9'd1;
  end

  // Registered read data. A write to the same address at the same edge
  // lands through the separate memory process, so this read returns the
  // old value (read-first behaviour).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_rdata <= 16'h0000;
    else if (w_in_run)
      r_rdata <= r_mem[cpu_addr];
    else
      r_rdata <= 16'h0000;
  end

  // The array has no reset; CLEAR is its only initialisation. Writes are
  // blocked while rst is high so reset does not silently modify address 0.
  always_ff @(posedge clk) begin
    if (w_mem_we && !rst)
      r_mem[w_mem_addr] <= w_mem_wdata;
  end

endmodule

// File: tb/tb_prog_memory.sv
// ---------------------------------------------------------------------------
// tb_prog_memory
//
// Directed testbench for prog_memory. The expected values are computed by
// hand. The expectations for the write-protect case depend on whether
// PROG_MEMORY_WPROT_EN is defined.
// ---------------------------------------------------------------------------
module tb_prog_memory;

  logic        clk;
  logic        rst;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_we;
  logic [15:0] cpu_rdata;
  logic        cpu_run;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [8:0]  prog_len;
  logic        wr_fault;

  int n_checks;
  int n_fails;

  prog_memory #(.CLR_VAL(16'h0000)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_rdata (cpu_rdata),
    .cpu_run   (cpu_run),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .prog_len  (prog_len),
    .wr_fault  (wr_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven at a negedge; the task then advances to the next
  // negedge, where outputs are sampled.
  task automatic ld_put(input logic v, input logic [15:0] d, input logic l);
    ld_valid = v;
    ld_data  = d;
    ld_last  = l;
    @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] a, output logic [15:0] d);
    cpu_addr = a;
    cpu_we   = 1'b0;
    @(negedge clk);
    d = cpu_rdata;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_we    = 1'b1;
    @(negedge clk);
    cpu_we    = 1'b0;
  endtask

  // Call this right after rst falls at a negedge. It counts negedges until
  // ld_ready rises (bounded) and checks that the CPU side stays quiet
  // throughout.
  task automatic wait_ready(input string tag);
    int cnt;
    int viol;
    cnt  = 0;
    viol = 0;
    while (cnt < 400) begin
      @(negedge clk);
      cnt++;
      if (cpu_run !== 1'b0 || cpu_rdata !== 16'h0000) viol++;
      if (ld_ready === 1'b1) break;
    end
    chk({tag, "_clr_cycles"}, cnt, 256);
    chk({tag, "_clr_quiet"}, viol, 0);
  endtask

  task automatic load3(input bit gapped);
    ld_put(1'b1, 16'h0232, 1'b0);
    if (gapped) ld_put(1'b0, 16'hBEEF, 1'b1);
    if (gapped) chk("gap_len1", prog_len, 1);
    ld_put(1'b1, 16'h013C, 1'b0);
    if (gapped) ld_put(1'b0, 16'hDEAD, 1'b1);
    ld_put(1'b1, 16'h0700, 1'b1);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  logic [15:0] rv;

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b1;
    cpu_addr  = 8'h00;
    cpu_wdata = 16'h0000;
    cpu_we    = 1'b0;
    ld_valid  = 1'b0;
    ld_data   = 16'h0000;
    ld_last   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ready", ld_ready, 0);
    chk("rst_run", cpu_run, 0);
    chk("rst_len", prog_len, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_fault", wr_fault, 0);

    // Clear after reset, then a contiguous three-word load
    rst = 1'b0;
    wait_ready("init");
    load3(1'b0);
    chk("l3_run", cpu_run, 1);
    chk("l3_len", prog_len, 3);
    chk("l3_ready", ld_ready, 0);
    rd(8'd0, rv);  chk("l3_rd0", rv, 16'h0232);
    rd(8'd1, rv);  chk("l3_rd1", rv, 16'h013C);
    rd(8'd2, rv);  chk("l3_rd2", rv, 16'h0700);
    rd(8'd50, rv); chk("l3_rd50", rv, 16'h0000);

    // Read-first: write and read the same address in one cycle
    cpu_addr  = 8'd60;
    cpu_wdata = 16'h00AA;
    cpu_we    = 1'b1;
    @(negedge clk);
    chk("rf_old", cpu_rdata, 16'h0000);
    cpu_we = 1'b0;
    @(negedge clk);
    chk("rf_new", cpu_rdata, 16'h00AA);
    chk("rf_fault", wr_fault, 0);

    // Write inside the loaded program
    wr(8'd1, 16'hFFFF);
    rd(8'd1, rv);
`ifdef PROG_MEMORY_WPROT_EN
    chk("wp_rd1", rv, 16'h013C);
    chk("wp_fault", wr_fault, 1);
`else
    chk("wp_rd1", rv, 16'hFFFF);
    chk("wp_fault", wr_fault, 0);
`endif
    chk("run_len_frozen", prog_len, 3);

    // Reset in RUN, then a gapped load that drives junk data and ld_last
    // while ld_valid is low
    rst = 1'b1;
    #1;
    chk("rrun_run", cpu_run, 0);
    chk("rrun_fault", wr_fault, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready("gap");
    load3(1'b1);
    chk("g3_run", cpu_run, 1);
    chk("g3_len", prog_len, 3);
    rd(8'd0, rv);  chk("g3_rd0", rv, 16'h0232);
    rd(8'd1, rv);  chk("g3_rd1", rv, 16'h013C);
    rd(8'd2, rv);  chk("g3_rd2", rv, 16'h0700);
    rd(8'd3, rv);  chk("g3_rd3", rv, 16'h0000);
    rd(8'd60, rv); chk("g3_rd60_cleared", rv, 16'h0000);

    // Full 256-word load with ld_last never set
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready("full");
    for (int i = 0; i < 256; i++) begin
      ld_put(1'b1, 16'hA500 ^ 16'(i), 1'b0);
      if (i == 254) begin
        chk("f_len255", prog_len, 255);
        chk("f_run_early", cpu_run, 0);
      end
    end
    chk("f_run", cpu_run, 1);
    chk("f_len", prog_len, 256);
    chk("f_ready", ld_ready, 0);
    ld_put(1'b1, 16'hDEAD, 1'b1);
    chk("f_len_hold", prog_len, 256);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    rd(8'd0, rv);   chk("f_rd0", rv, 16'hA500);
    rd(8'd128, rv); chk("f_rd128", rv, 16'hA580);
    rd(8'd255, rv); chk("f_rd255", rv, 16'hA5FF);

    // Reset after five loader words
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready("part");
    for (int i = 0; i < 5; i++) ld_put(1'b1, 16'h1110 + 16'(i), 1'b0);
    chk("p_len5", prog_len, 5);
    rst = 1'b1;
    #1;
    chk("p_rst_ready", ld_ready, 0);
    chk("p_rst_len", prog_len, 0);
    chk("p_rst_run", cpu_run, 0);
    chk("p_rst_rdata", cpu_rdata, 0);
    chk("p_rst_fault", wr_fault, 0);
    ld_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_ready("prel");
    chk("p_len_after", prog_len, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/prog_memory.md
PROG_MEMORY -- requirements
Module: prog_memory

Interface
REQ-001 Parameter: CLR_VAL, 16'h0000, fill word written to every location during CLEAR.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cpu_addr  input  8  CPU memory address (CPU MAR).
REQ-005 cpu_wdata  input  16  CPU write data (CPU MBR out).
REQ-006 cpu_we  input  1  CPU write strobe (CPU control signal C11).
REQ-007 cpu_rdata  output  16  registered read data to CPU MBR in.
REQ-008 cpu_run  output  1  high = program loaded, CPU may leave reset.
REQ-009 ld_valid  input  1  loader word valid.
REQ-010 ld_data  input  16  loader word (opcode[15:8], operand[7:0]).
REQ-011 ld_last  input  1  qualifies final loader word.
REQ-012 ld_ready  output  1  block accepts a loader word this cycle.
REQ-013 prog_len  output  9  count of words accepted by loader, 0..256.
REQ-014 wr_fault  output  1  sticky write-protect violation flag.

Function
REQ-015 Storage: 256 x 16-bit words, addresses 0..255, all usable.
REQ-016 States: CLEAR -> LOAD -> RUN; no other transitions except reset.
REQ-017 CLEAR: one location per cycle, addresses 0..255 ascending, written with CLR_VAL; exactly 256 cycles, then LOAD.
REQ-018 LOAD: ld_ready=1 (decoded from registered state only, not from ld_valid); transfer when ld_valid&&ld_ready.
REQ-019 Each transfer writes ld_data to address prog_len[7:0], then prog_len increments by 1.
REQ-020 Transfer with ld_last=1, or transfer at address 255 (regardless of ld_last), -> RUN next cycle; prog_len never wraps (max 256).
REQ-021 ld_valid low in LOAD: no write, no count change, wait indefinitely; ld_valid/ld_last ignored outside LOAD.
REQ-022 RUN: cpu_run=1, ld_ready=0; every cycle cpu_rdata <= mem[cpu_addr] (1-cycle latency).
REQ-023 RUN with cpu_we=1: mem[cpu_addr] <= cpu_wdata at the same edge; read is read-first (same-cycle read of written address returns old value).
REQ-024 Outside RUN: cpu_we ignored, cpu_rdata held 16'h0000, cpu_run=0.
REQ-025 prog_len frozen in RUN.

Reset
REQ-026 rst asserted (any state, any cycle): state=CLEAR, clear pointer=0, prog_len=0, cpu_rdata=0, cpu_run=0, ld_ready=0, wr_fault=0, immediately and asynchronously.
REQ-027 Reset mid-LOAD or mid-RUN discards the program; full CLEAR repeats after deassertion.
REQ-028 Memory array itself is not reset; CLEAR is the only initialisation.

Configuration
REQ-029 Macro PROG_MEMORY_WPROT_EN defined: RUN-state write with cpu_addr < prog_len is suppressed and sets wr_fault, which stays 1 until rst.
REQ-030 Macro absent: all RUN-state writes performed; wr_fault tied to 0.

Verification
REQ-031 Release rst, ld_valid=0 -> ld_ready rises exactly 256 cycles after release; cpu_run=0, cpu_rdata=0 throughout.
REQ-032 Load 0x0232, 0x013C, 0x0700 (ld_last on third) -> prog_len=3, cpu_run=1 next cycle; read addr 2 -> 0x0700 one cycle later; addr 50 -> 0x0000.
REQ-033 Same load with ld_valid gapped every other cycle -> identical contents and prog_len=3; no extra writes.
REQ-034 RUN: write addr 60 = 0x00AA while reading addr 60 -> cpu_rdata 0x0000 that cycle, 0x00AA on next read.
REQ-035 With PROG_MEMORY_WPROT_EN, write addr 1 = 0xFFFF after REQ-032 load -> addr 1 reads 0x013C, wr_fault=1; without macro -> reads 0xFFFF, wr_fault=0.
REQ-036 Load 256 words, ld_last never set -> RUN after word 255, prog_len=256; separately, assert rst after 5 load words -> all outputs 0 at once, ld_ready returns 256 cycles after release.
